prog_load_rx: RTL



---
 rtl/prog_if_pkg.sv | 17 +
 rtl/debounce_sync.sv | 66 ++++++
 rtl/prog_load_rx.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/prog_if_pkg.sv
// Shared types and defaults for the front-panel program loader.
package prog_if_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARM     = 3'd1,
      CAPTURE = 3'd2,
      WRITE   = 3'd3,
      RELEASE = 3'd4
   } prog_state_e;

   localparam int DEF_ADDR_WIDTH      = 5;
   localparam int DEF_SYNC_STAGES     = 2;
   localparam int DEF_DEBOUNCE_CYCLES = 4;
   localparam int PROG_DATA_W         = 8;

endpackage

// File: rtl/debounce_sync.sv
// Synchronizer plus debouncer: an accepted level that flips only after a run of
// identical synchronized samples, with one-cycle rise/fall pulses on each flip.
module debounce_sync #(
   parameter int   SYNC_STAGES     = 2,
   parameter int   DEBOUNCE_CYCLES = 4,
   parameter logic RESET_VAL       = 1'b0
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic din_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
   logic                   fall_q, fall_d;
   logic                   sync_s;

   assign sync_s = sync_q[SYNC_STAGES-1];

   // cnt_q counts consecutive samples that disagree with the accepted level
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
      fall_d  = 1'b0;
      if (sync_s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == LAST_CNT) begin
         cnt_d   = '0;
         level_d = sync_s;
         rise_d  = sync_s;
         fall_d  = ~sync_s;
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sync_q  <= {SYNC_STAGES{RESET_VAL}};
         cnt_q   <= '0;
         level_q <= RESET_VAL;
         rise_q  <= 1'b0;
         fall_q  <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], din_i};
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
         fall_q  <= fall_d;
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
   assign fall_o  = fall_q;

endmodule

// File: rtl/prog_load_rx.sv
// Front-panel program loader: one debounced strobe press writes the data
// switches to the next instruction-memory address.
module prog_load_rx
   import prog_if_pkg::*;
#(
   parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   prog_mode,
   input  logic                   prog_strobe_n,
   input  logic [PROG_DATA_W-1:0] prog_data,
   output logic                   mem_we,
   output logic [ADDR_WIDTH-1:0]  mem_addr,
   output logic [PROG_DATA_W-1:0] mem_wdata,
   output logic [ADDR_WIDTH:0]    byte_count,
   output logic                   busy,
   output logic                   overflow
);

   localparam logic [ADDR_WIDTH:0] FULL_COUNT = {1'b1, {ADDR_WIDTH{1'b0}}};

   prog_state_e            state_q;
   logic                   mem_we_q;
   logic [ADDR_WIDTH-1:0]  mem_addr_q;
   logic [PROG_DATA_W-1:0] mem_wdata_q;
   logic [ADDR_WIDTH:0]    byte_count_q;
   logic                   busy_q;
   logic                   overflow_q;

   logic [PROG_DATA_W-1:0] data_sync_q [SYNC_STAGES];

   logic mode_s, mode_rise_s, mode_fall_s;
   logic strobe_level_s, release_s, press_s;
   logic unused_dbnc_s;

   // Strobe idles high, so its debouncer resets to the released level
   debounce_sync #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VAL       (1'b1)
   ) u_strobe_dbnc (
      .clk_i   (clock),
      .rst_i   (reset),
      .din_i   (prog_strobe_n),
      .level_o (strobe_level_s),
      .rise_o  (release_s),
      .fall_o  (press_s)
   );

   debounce_sync #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (1),
      .RESET_VAL       (1'b0)
   ) u_mode_dbnc (
      .clk_i   (clock),
      .rst_i   (reset),
      .din_i   (prog_mode),
      .level_o (mode_s),
      .rise_o  (mode_rise_s),
      .fall_o  (mode_fall_s)
   );

   assign unused_dbnc_s = ^{mode_rise_s, mode_fall_s, strobe_level_s};

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) data_sync_q[i] <= '0;
      end else begin
         data_sync_q[0] <= prog_data;
         for (int i = 1; i < SYNC_STAGES; i++) data_sync_q[i] <= data_sync_q[i-1];
      end
   end

   // A dropped mode always wins over any press seen in the same cycle
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= IDLE;
         mem_we_q     <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         byte_count_q <= '0;
         busy_q       <= 1'b0;
         overflow_q   <= 1'b0;
      end else begin
         mem_we_q <= 1'b0;
         case (state_q)
            IDLE: begin
               busy_q <= 1'b0;
               if (mode_s) begin
                  state_q      <= ARM;
                  byte_count_q <= '0;
                  mem_addr_q   <= '0;
                  overflow_q   <= 1'b0;
               end else begin
                  state_q <= IDLE;
               end
            end
            ARM: begin
               if (!mode_s) begin
                  state_q <= IDLE;
               end else if (press_s) begin
                  state_q <= CAPTURE;
                  busy_q  <= 1'b1;
               end else begin
                  state_q <= ARM;
               end
            end
            CAPTURE: begin
               if (!mode_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  mem_wdata_q <= data_sync_q[SYNC_STAGES-1];
                  if (byte_count_q == FULL_COUNT) begin
                     overflow_q <= 1'b1;
                     state_q    <= RELEASE;
                  end else begin
                     mem_we_q <= 1'b1;
                     state_q  <= WRITE;
                  end
               end
            end
            WRITE: begin
               // The write cycle itself cannot be interrupted by a mode drop
               mem_addr_q   <= mem_addr_q + ADDR_WIDTH'(1);
               byte_count_q <= byte_count_q + (ADDR_WIDTH + 1)'(1);
               if (!mode_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= RELEASE;
               end
            end
            RELEASE: begin
               if (!mode_s) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
               end else if (release_s) begin
                  state_q <= ARM;
                  busy_q  <= 1'b0;
               end else begin
                  state_q <= RELEASE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign mem_we     = mem_we_q;
   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign byte_count = byte_count_q;
   assign busy       = busy_q;
   assign overflow   = overflow_q;

endmodule
